// File: rtl/dec2to4_pkg.sv
// rtl/dec2to4_pkg.sv - shared select codes, decoded-vector type and helpers for dec2to4_reg
//
// Purpose : common definitions for the registered 2-to-4 decoder slice.
// Contents: SEL_I0..SEL_I3 select codes ({a,b}, a = MSB)
//           dec_vec_t    decoded vector, bit k drives output ik
//           onehot0()    true when at most one bit of a decoded vector is set
//           apply_pol()  maps an active-high decoded vector onto the output level
// Optional feature macro used by users of this package: DEC2TO4_ONEHOT_CHECK_EN

package dec2to4_pkg;

   localparam logic [1:0] SEL_I0 = 2'b00;
   localparam logic [1:0] SEL_I1 = 2'b01;
   localparam logic [1:0] SEL_I2 = 2'b10;
   localparam logic [1:0] SEL_I3 = 2'b11;

   // Bit k of the vector corresponds to output ik; always active-high internally.
   typedef logic [3:0] dec_vec_t;

   // Clearing the lowest set bit leaves zero only when at most one bit was set.
   function automatic logic onehot0(input dec_vec_t v);
      return ((v & (v - 4'd1)) == 4'd0);
   endfunction

   // Inversion happens after the decode so the inactive (and reset) level
   // follows the selected polarity automatically.
   function automatic dec_vec_t apply_pol(input dec_vec_t v, input logic active_low);
      return active_low ? ~v : v;
   endfunction

endpackage

// File: rtl/dec2to4_core.sv
// rtl/dec2to4_core.sv - purely combinational 2-to-4 decode with enable
//
// Purpose : decodes a 2-bit select into an active-high one-hot vector.
// Ports   : sel [1:0] in  - select code, sel[1] is the MSB (a), sel[0] the LSB (b)
//           en        in  - enable; when low the vector is all zeros
//           dec [3:0] out - decoded vector, bit k set iff en=1 and sel==k

module dec2to4_core
   import dec2to4_pkg::*;
(
   input  logic [1:0] sel,
   input  logic       en,
   output dec_vec_t   dec
);

   always_comb begin
      dec = '0;
      if (en) begin
         case (sel)
            SEL_I0:  dec[0] = 1'b1;
            SEL_I1:  dec[1] = 1'b1;
            SEL_I2:  dec[2] = 1'b1;
            SEL_I3:  dec[3] = 1'b1;
            default: dec    = '0;
         endcase
      end
   end

endmodule

// File: rtl/dec2to4_reg.sv
// rtl/dec2to4_reg.sv - registered 2-to-4 line decoder with enable, polarity and optional one-hot checker
//
// Purpose : select/address decoder feeding synchronous logic; outputs flopped on clk
//           (OUT_REG=1) or taken straight from the decode (OUT_REG=0).
// Params  : OUT_REG    1 = one-cycle registered outputs, 0 = combinational outputs
//           ACTIVE_LOW 1 = outputs asserted low (inactive/reset level is 1)
// Ports   : clk  in  - rising-edge clock
//           rst  in  - asynchronous reset, active-high; forces outputs inactive at once
//           a    in  - select MSB
//           b    in  - select LSB
//           en   in  - decoder enable, active-high
//           i0..i3 out - ik asserted when en=1 and {a,b}==k
//           err  out - (DEC2TO4_ONEHOT_CHECK_EN only) sticky decode-integrity flag
// Macro   : DEC2TO4_ONEHOT_CHECK_EN adds the err port, its checker and an assertion.

module dec2to4_reg
   import dec2to4_pkg::*;
#(
   parameter int OUT_REG    = 1,
   parameter int ACTIVE_LOW = 0
)
(
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic en,
   output logic i0,
   output logic i1,
   output logic i2,
   output logic i3
`ifdef DEC2TO4_ONEHOT_CHECK_EN
  ,output logic err
`endif
);

   logic [1:0] w_sel;
   dec_vec_t   w_core_dec;
   dec_vec_t   w_dec_q;
   dec_vec_t   w_dec_out;

   assign w_sel = {a, b};

   dec2to4_core u_core (
      .sel (w_sel),
      .en  (en),
      .dec (w_core_dec)
   );

   // The register stores the active-high decode so that its reset value of
   // zero always means "inactive", whatever the output polarity.
   if (OUT_REG != 0) begin : g_reg
      dec_vec_t r_dec;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_dec <= '0;
         end else begin
            r_dec <= w_core_dec;
         end
      end

      assign w_dec_q = r_dec;
   end else begin : g_comb
      assign w_dec_q = w_core_dec;
   end

   assign w_dec_out = apply_pol(w_dec_q, ACTIVE_LOW != 0);

   assign i0 = w_dec_out[0];
   assign i1 = w_dec_out[1];
   assign i2 = w_dec_out[2];
   assign i3 = w_dec_out[3];

`ifdef DEC2TO4_ONEHOT_CHECK_EN
   // Checked on the active-high core vector: enabled decodes must be exactly
   // one-hot, disabled decodes must be all zero.
   logic w_violation;
   logic r_err;

   assign w_violation = en ? !(onehot0(w_core_dec) && (w_core_dec != '0))
                           : (w_core_dec != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_violation) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;

`ifndef SYNTHESIS
   a_dec_onehot: assert property (@(posedge clk) disable iff (rst) !w_violation)
      else $warning("dec2to4_reg: decoded vector %b violates one-hot rule with en=%b",
                    w_core_dec, en);
`endif
`endif

endmodule

// File: tb/tb_dec2to4_reg.sv
// tb/tb_dec2to4_reg.sv - randomized self-checking bench for dec2to4_reg against a behavioural model

module tb_dec2to4_reg;

   logic clk;
   logic rst;
   logic a;
   logic b;
   logic en;

   logic d0, d1, d2, d3;
   logic l0, l1, l2, l3;
   logic c0, c1, c2, c3;
`ifdef DEC2TO4_ONEHOT_CHECK_EN
   logic d_err, l_err, c_err;
`endif

   logic [3:0] v_dut, v_al, v_comb;
   assign v_dut  = {d3, d2, d1, d0};
   assign v_al   = {l3, l2, l1, l0};
   assign v_comb = {c3, c2, c1, c0};

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // Model state: active-high decode of the last capture since reset.
   logic [3:0] m_cap = 4'b0000;
   logic [3:0] e_reg;
   logic [3:0] sweep_exp [4];

   dec2to4_reg #(.OUT_REG(1), .ACTIVE_LOW(0)) u_dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
      .i0(d0), .i1(d1), .i2(d2), .i3(d3)
`ifdef DEC2TO4_ONEHOT_CHECK_EN
     ,.err(d_err)
`endif
   );

   dec2to4_reg #(.OUT_REG(1), .ACTIVE_LOW(1)) u_dut_al (
      .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
      .i0(l0), .i1(l1), .i2(l2), .i3(l3)
`ifdef DEC2TO4_ONEHOT_CHECK_EN
     ,.err(l_err)
`endif
   );

   dec2to4_reg #(.OUT_REG(0), .ACTIVE_LOW(0)) u_dut_comb (
      .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
      .i0(c0), .i1(c1), .i2(c2), .i3(c3)
`ifdef DEC2TO4_ONEHOT_CHECK_EN
     ,.err(c_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] dec_model(input logic e, input logic [1:0] s);
      return e ? (4'd1 << s) : 4'd0;
   endfunction

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic e, input logic [1:0] s);
      en    = e;
      {a, b} = s;
   endtask

   always @(posedge rst) m_cap = 4'b0000;
   always @(posedge clk) if (!rst) m_cap = dec_model(en, {a, b});

   always @(negedge clk) begin
      if (chk_on) begin
         e_reg = rst ? 4'b0000 : m_cap;
         check4("reg_model",  v_dut,  e_reg);
         check4("al_model",   v_al,   ~e_reg);
         check4("comb_model", v_comb, dec_model(en, {a, b}));
`ifdef DEC2TO4_ONEHOT_CHECK_EN
         check4("err_clean", {1'b0, d_err, l_err, c_err}, 4'b0000);
`endif
      end
   end

   initial begin
      sweep_exp[0] = 4'b0001;
      sweep_exp[1] = 4'b0010;
      sweep_exp[2] = 4'b0100;
      sweep_exp[3] = 4'b1000;

      rst = 1'b0;
      drive(1'b0, 2'b00);
      #1 rst = 1'b1;
      #1;
      check4("reset_async", v_dut, 4'b0000);
      check4("reset_al",    v_al,  4'b1111);

      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      chk_on = 1'b1;
      @(posedge clk);
      #1 check4("after_release", v_dut, 4'b0000);

      for (int k = 0; k < 4; k++) begin
         #1 drive(1'b1, 2'(k));
         #1 check4("comb_sweep", v_comb, sweep_exp[k]);
         @(posedge clk);
         #1 check4("reg_sweep", v_dut, sweep_exp[k]);
      end

      #1 drive(1'b1, 2'b10);
      @(posedge clk);
      #1 check4("gate_on", v_dut, 4'b0100);
      #1 drive(1'b0, 2'b10);
      @(posedge clk);
      #1 check4("gate_off", v_dut, 4'b0000);

      #1 drive(1'b1, 2'b01);
      @(posedge clk);
      #1 check4("rst_pre", v_dut, 4'b0010);
      #1 rst = 1'b1;
      #1 check4("rst_mid", v_dut, 4'b0000);
      check4("rst_mid_al", v_al, 4'b1111);
      @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 check4("rst_post", v_dut, 4'b0010);

      #1 drive(1'b1, 2'b11);
      @(posedge clk);
      #1 check4("al_sel3", v_al, 4'b0111);

      for (int n = 0; n < 400; n++) begin
         @(posedge clk);
         #2;
         en     = ($urandom_range(0, 3) != 0);
         {a, b} = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            #4 rst = 1'b0;
         end
      end

`ifdef DEC2TO4_ONEHOT_CHECK_EN
      @(posedge clk);
      chk_on = 1'b0;
      #1 check4("err_sweep", {3'b000, d_err}, 4'b0000);
      #1 drive(1'b1, 2'b00);
      force u_dut.w_core_dec = 4'b0011;
      @(posedge clk);
      #1 check4("err_set", {3'b000, d_err}, 4'b0001);
      release u_dut.w_core_dec;
      repeat (3) @(posedge clk);
      #1 check4("err_hold", {1'b0, d_err, l_err, c_err}, 4'b0100);
      rst = 1'b1;
      #1 check4("err_clear", {3'b000, d_err}, 4'b0000);
      #1 rst = 1'b0;
`endif

      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
